painterengine_gpu_writer_feeder: RTL and testbench
==================================================

Name: painterengine_gpu_writer_feeder

Overview:
- Pixel staging stage directly upstream of the GPU DMA writer. Drives one 32-bit data/valid lane of the writer and advances on the writer's per-lane next strobe.
- Accepts source pixels over a valid/ready handshake, converts them to ARGB8888 (or generates a solid fill), and buffers them in a first-word-fall-through FIFO.
- Stops after exactly the programmed pixel count, so the writer never sees surplus data.

Parameters:
- PARAM_DEPTH_LOG2, 4, FIFO depth is 2**PARAM_DEPTH_LOG2 entries of 32 bits.
- PARAM_ALPHA, 8'hFF, alpha byte inserted for RGB565 expansion.

Ports:
- i_wire_clock  in  1  clock.
- i_wire_resetn  in  1  asynchronous active-low reset.
- i_wire_start  in  1  one-cycle job start pulse. Honoured only in IDLE or DONE.
- i_wire_length  in  32  pixel count, sampled on start.
- i_wire_format  in  2  sampled on start. 0 = ARGB8888 passthrough; 1 = RGB565 expand; 2 = solid fill; 3 = illegal.
- i_wire_color  in  32  fill colour, sampled on start.
- i_wire_src_data  in  32  source pixel. Only [15:0] is used in format 1.
- i_wire_src_valid  in  1  source pixel valid.
- o_wire_src_ready  out  1  source pixel accepted when valid&&ready.
- o_wire_data  out  32  pixel presented to the writer lane.
- o_wire_data_valid  out  1  o_wire_data is valid.
- i_wire_data_next  in  1  writer consumed o_wire_data this cycle.
- o_wire_level  out  PARAM_DEPTH_LOG2+1  FIFO occupancy.
- o_wire_busy  out  1  state is RUN or DRAIN.
- o_wire_done  out  1  state is DONE.
- o_wire_error  out  1  state is ERROR.
- o_wire_error_type  out  2  0 = none; 1 = zero length; 2 = illegal format; 3 = next without valid.

Behaviour:
- Reset values: all outputs 0; FIFO pointers 0; counters 0; state IDLE. Reset mid-job aborts immediately and discards FIFO contents.
- States: IDLE, RUN, DRAIN, DONE, ERROR.
- IDLE/DONE + start:
  - Latch length/format/color; clear in_count, out_count and FIFO pointers.
  - length==0 -> ERROR type 1; format==3 -> ERROR type 2 (zero length has priority).
  - Otherwise -> RUN.
- RUN, push side:
  - push = (valid_src || format==2) && !full && in_count<length.
  - o_wire_src_ready = (state==RUN) && format!=2 && !full && in_count<length.
  - Full is decided from the registered level; a same-cycle pop does not free a slot for a push.
  - Each push increments in_count.
  - When a push makes in_count==length -> DRAIN in the same cycle; src_ready deasserts the following cycle.
- Conversion, applied at push:
  - Format 0: stored as-is.
  - Format 1: stored as {PARAM_ALPHA, R5,R5[4:2], G6,G6[5:4], B5,B5[4:2]}, where R=[15:11], G=[10:5], B=[4:0].
  - Format 2: stores the latched color.
- Pop side:
  - o_wire_data is the FIFO head, combinational from the read pointer (FWFT).
  - o_wire_data_valid = (RUN||DRAIN) && level!=0.
  - A pop occurs on next&&valid: read pointer advances, out_count increments.
  - Latency: a pixel pushed at edge N is visible with valid high after edge N.
- Simultaneous push and pop: level unchanged; both pointers advance. Pointers wrap modulo depth; level tracks 0..depth inclusive.
- DRAIN: no pushes. When a pop makes out_count==length -> DONE (level is 0 at that point). Valid drops in the same edge.
- Protocol error: next asserted while state is RUN/DRAIN and valid is low -> ERROR type 3. No pointer change.
- ERROR is sticky until reset; start is ignored. DONE holds until the next start.
- Start while RUN/DRAIN is ignored.

Test Plan:
- Format 0, length 5, source streams 0x11..0x55 back-to-back, next tied high:
  - o_wire_data shows 0x11..0x55 in order, one per cycle after first-push latency.
  - Exactly 5 pops; done rises the cycle after the 5th pop; 6th source word never gets ready.
- Format 1, length 1, src_data 0xF81F:
  - o_wire_data = 0xFFFF00FF.
  - Repeat with PARAM_ALPHA=0x80 -> 0x80FF00FF.
- Format 2, color 0xDEADBEEF, length 40, depth 16, next held low 30 cycles then high:
  - level saturates at 16 and src_ready stays 0.
  - All 40 outputs are 0xDEADBEEF; done afterwards.
- Full-plus-pop corner: FIFO full, src_valid and next both high for 1 cycle:
  - level 16 -> 15; no push that cycle; push resumes on the next cycle.
- Error cases:
  - start with length 0 -> error, type 1.
  - format 3 -> error, type 2.
  - next pulsed while empty in RUN -> error, type 3.
  - For each: a subsequent start is ignored until reset.
- Reset asserted mid-DRAIN with level 7:
  - All outputs 0 immediately (asynchronous).
  - After release, a new start with length 2 completes cleanly with no stale data.

Source files
------------

// File: rtl/painterengine_gpu_writer_feeder.sv
// painterengine_gpu_writer_feeder
//   Pixel staging stage in front of one lane of the GPU DMA writer. It takes
//   source pixels over valid/ready. Each pixel is converted to ARGB8888, or a
//   solid fill colour is generated instead. Pixels are buffered in a
//   first-word-fall-through FIFO, and the stage stops after exactly the
//   programmed pixel count.
//
// Ports
//   i_wire_clock, i_wire_resetn     clock, asynchronous active-low reset
//   i_wire_start                    one-cycle job start (IDLE/DONE only)
//   i_wire_length/format/color      job setup, sampled on start
//   i_wire_src_data/src_valid       source pixel stream
//   o_wire_src_ready                source pixel accepted when valid&&ready
//   o_wire_data/data_valid          FIFO head presented to the writer lane
//   i_wire_data_next                writer consumed o_wire_data this cycle
//   o_wire_level                    FIFO occupancy (0..depth)
//   o_wire_busy/done/error          RUN|DRAIN / DONE / ERROR state flags
//   o_wire_error_type               1 zero length, 2 bad format, 3 next w/o valid
module painterengine_gpu_writer_feeder #(
    parameter int         PARAM_DEPTH_LOG2 = 4,
    parameter logic [7:0] PARAM_ALPHA      = 8'hFF
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_resetn,
    input  logic                        i_wire_start,
    input  logic [31:0]                 i_wire_length,
    input  logic [1:0]                  i_wire_format,
    input  logic [31:0]                 i_wire_color,
    input  logic [31:0]                 i_wire_src_data,
    input  logic                        i_wire_src_valid,
    output logic                        o_wire_src_ready,
    output logic [31:0]                 o_wire_data,
    output logic                        o_wire_data_valid,
    input  logic                        i_wire_data_next,
    output logic [PARAM_DEPTH_LOG2:0]   o_wire_level,
    output logic                        o_wire_busy,
    output logic                        o_wire_done,
    output logic                        o_wire_error,
    output logic [1:0]                  o_wire_error_type
);

    localparam int DEPTH   = 1 << PARAM_DEPTH_LOG2;
    localparam int LEVEL_W = PARAM_DEPTH_LOG2 + 1;
    localparam logic [PARAM_DEPTH_LOG2:0] LEVEL_FULL = LEVEL_W'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    logic [2:0]                  state;
    logic [31:0]                 length;
    logic [1:0]                  format;
    logic [31:0]                 color;
    logic [31:0]                 in_count;
    logic [31:0]                 out_count;
    logic [PARAM_DEPTH_LOG2-1:0] wr_ptr;
    logic [PARAM_DEPTH_LOG2-1:0] rd_ptr;
    logic [PARAM_DEPTH_LOG2:0]   level;
    logic [1:0]                  error_type;
    logic [31:0]                 mem [DEPTH];

    logic        active;
    logic        full;
    logic        room;
    logic        push;
    logic        pop;
    logic        data_valid;
    logic        proto_err;
    logic [31:0] pixel;

    assign active     = (state == ST_RUN) || (state == ST_DRAIN);
    // Full comes from the registered level, so a pop in the same cycle
    // never makes room for a push.
    assign full       = (level == LEVEL_FULL);
    assign room       = (in_count < length);
    assign push       = (state == ST_RUN) && (i_wire_src_valid || format == 2'd2)
                        && !full && room;
    assign data_valid = active && (level != '0);
    assign pop        = i_wire_data_next && data_valid;
    assign proto_err  = active && i_wire_data_next && !data_valid;

    always_comb begin
        pixel = i_wire_src_data;
        case (format)
            2'd1: pixel = {PARAM_ALPHA,
                           i_wire_src_data[15:11], i_wire_src_data[15:13],
                           i_wire_src_data[10:5],  i_wire_src_data[10:9],
                           i_wire_src_data[4:0],   i_wire_src_data[4:2]};
            2'd2: pixel = color;
            default: pixel = i_wire_src_data;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state      <= ST_IDLE;
            length     <= '0;
            format     <= '0;
            color      <= '0;
            in_count   <= '0;
            out_count  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            error_type <= '0;
            // The storage is cleared too, so the combinational head reads 0 in reset.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_wire_start) begin
                        length    <= i_wire_length;
                        format    <= i_wire_format;
                        color     <= i_wire_color;
                        in_count  <= '0;
                        out_count <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        level     <= '0;
                        if (i_wire_length == '0) begin
                            state      <= ST_ERROR;
                            error_type <= 2'd1;
                        end else if (i_wire_format == 2'd3) begin
                            state      <= ST_ERROR;
                            error_type <= 2'd2;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (proto_err) begin
                        state      <= ST_ERROR;
                        error_type <= 2'd3;
                    end else begin
                        if (push) begin
                            mem[wr_ptr] <= pixel;
                            wr_ptr      <= wr_ptr + 1'b1;
                            in_count    <= in_count + 32'd1;
                            if (in_count + 32'd1 == length) begin
                                state <= ST_DRAIN;
                            end
                        end
                        if (pop) begin
                            rd_ptr    <= rd_ptr + 1'b1;
                            out_count <= out_count + 32'd1;
                            if ((state == ST_DRAIN) && (out_count + 32'd1 == length)) begin
                                state <= ST_DONE;
                            end
                        end
                        if (push && !pop) begin
                            level <= level + 1'b1;
                        end else if (!push && pop) begin
                            level <= level - 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wire_src_ready  = (state == ST_RUN) && (format != 2'd2) && !full && room;
    assign o_wire_data       = mem[rd_ptr];
    assign o_wire_data_valid = data_valid;
    assign o_wire_level      = level;
    assign o_wire_busy       = active;
    assign o_wire_done       = (state == ST_DONE);
    assign o_wire_error      = (state == ST_ERROR);
    assign o_wire_error_type = error_type;

endmodule

// File: tb/tb_painterengine_gpu_writer_feeder.sv
// tb_painterengine_gpu_writer_feeder
//   Directed bench for painterengine_gpu_writer_feeder. Instance a uses the
//   default alpha. Instance b shares all inputs and overrides PARAM_ALPHA to
//   8'h80. In "follow" mode the writer's next strobe mirrors instance a's
//   valid, modelling a writer that always accepts.
module tb_painterengine_gpu_writer_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] length;
    logic [1:0]  format;
    logic [31:0] color;
    logic [31:0] src_data;
    logic        src_valid;
    logic        next_man;
    logic        follow;
    logic        next;

    logic        a_ready, a_valid, a_busy, a_done, a_error;
    logic [31:0] a_data;
    logic [4:0]  a_level;
    logic [1:0]  a_etype;
    logic        b_ready, b_valid, b_busy, b_done, b_error;
    logic [31:0] b_data;
    logic [4:0]  b_level;
    logic [1:0]  b_etype;

    int n_tests = 0;
    int n_fail  = 0;

    assign next = follow ? a_valid : next_man;

    painterengine_gpu_writer_feeder #(.PARAM_DEPTH_LOG2(4), .PARAM_ALPHA(8'hFF)) dut_a (
        .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_start(start),
        .i_wire_length(length), .i_wire_format(format), .i_wire_color(color),
        .i_wire_src_data(src_data), .i_wire_src_valid(src_valid),
        .o_wire_src_ready(a_ready), .o_wire_data(a_data), .o_wire_data_valid(a_valid),
        .i_wire_data_next(next), .o_wire_level(a_level), .o_wire_busy(a_busy),
        .o_wire_done(a_done), .o_wire_error(a_error), .o_wire_error_type(a_etype)
    );

    painterengine_gpu_writer_feeder #(.PARAM_DEPTH_LOG2(4), .PARAM_ALPHA(8'h80)) dut_b (
        .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_start(start),
        .i_wire_length(length), .i_wire_format(format), .i_wire_color(color),
        .i_wire_src_data(src_data), .i_wire_src_valid(src_valid),
        .o_wire_src_ready(b_ready), .o_wire_data(b_data), .o_wire_data_valid(b_valid),
        .i_wire_data_next(next), .o_wire_level(b_level), .o_wire_busy(b_busy),
        .o_wire_done(b_done), .o_wire_error(b_error), .o_wire_error_type(b_etype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] len, input logic [1:0] fmt, input logic [31:0] col);
        start  = 1'b1;
        length = len;
        format = fmt;
        color  = col;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int pops;
        int src_idx;
        int first_cyc;
        int done_cyc;
        logic hs;

        rst_n = 1'b0; start = 1'b0; length = '0; format = '0; color = '0;
        src_data = '0; src_valid = 1'b0; next_man = 1'b0; follow = 1'b0;

        // Reset state
        #3;
        chk("rst_data",  a_data, 32'h0);
        chk("rst_valid", {31'b0, a_valid}, 32'h0);
        chk("rst_ready", {31'b0, a_ready}, 32'h0);
        chk("rst_level", {27'b0, a_level}, 32'h0);
        chk("rst_flags", {29'b0, a_busy, a_done, a_error}, 32'h0);
        chk("rst_etype", {30'b0, a_etype}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Format 0, length 5, back-to-back source, writer always accepting
        follow = 1'b1; src_valid = 1'b1; src_idx = 0; src_data = 32'h11;
        pops = 0; first_cyc = -1; done_cyc = -1;
        do_start(32'd5, 2'd0, 32'h0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (a_done) begin
                done_cyc = cyc;
                break;
            end
            if (a_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("f0_data", a_data, 32'h11 * (pops + 1));
                pops++;
            end
            if (a_ready) chk("f0_ready_limit", src_idx, 32'd0 + (src_idx < 5 ? src_idx : 4));
            hs = a_ready && src_valid;
            tick();
            if (hs) begin
                src_idx++;
                src_data = 32'h11 * (src_idx + 1);
            end
        end
        src_valid = 1'b0;
        chk("f0_pops", pops, 32'd5);
        chk("f0_first_valid_cyc", first_cyc, 32'd1);
        chk("f0_done_cyc", done_cyc, 32'd6);
        chk("f0_accepted", src_idx, 32'd5);
        chk("f0_valid_at_done", {31'b0, a_valid}, 32'h0);

        // Format 1, RGB565 expansion with both alpha values
        src_data = 32'h0000_F81F; src_valid = 1'b1;
        do_start(32'd1, 2'd1, 32'h0);
        tick();
        src_valid = 1'b0;
        chk("f1_data_alpha_ff", a_data, 32'hFFFF00FF);
        chk("f1_data_alpha_80", b_data, 32'h80FF00FF);
        chk("f1_valid", {31'b0, a_valid}, 32'h1);
        chk("f1_ready_after_last", {31'b0, a_ready}, 32'h0);
        tick();
        chk("f1_done", {31'b0, a_done}, 32'h1);

        // Format 2, solid fill, 40 pixels, writer stalled for 30 cycles
        follow = 1'b0; next_man = 1'b0; src_valid = 1'b1;
        do_start(32'd40, 2'd2, 32'hDEADBEEF);
        repeat (30) tick();
        chk("f2_level_sat", {27'b0, a_level}, 32'd16);
        chk("f2_ready", {31'b0, a_ready}, 32'h0);
        chk("f2_head", a_data, 32'hDEADBEEF);
        // Full FIFO with a pop: slot is not reused in the same cycle
        next_man = 1'b1;
        tick();
        next_man = 1'b0;
        chk("full_pop_level", {27'b0, a_level}, 32'd15);
        tick();
        chk("push_resume_level", {27'b0, a_level}, 32'd16);
        pops = 1;
        follow = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (a_done) break;
            if (a_valid) begin
                chk("f2_data", a_data, 32'hDEADBEEF);
                pops++;
            end
            tick();
        end
        src_valid = 1'b0;
        chk("f2_pops", pops, 32'd40);
        chk("f2_done", {31'b0, a_done}, 32'h1);
        chk("f2_level_end", {27'b0, a_level}, 32'd0);

        // Asynchronous reset mid-DRAIN with 7 entries buffered
        follow = 1'b0; next_man = 1'b0;
        do_start(32'd7, 2'd2, 32'h12345678);
        repeat (7) tick();
        chk("drain_busy", {31'b0, a_busy}, 32'h1);
        chk("drain_level", {27'b0, a_level}, 32'd7);
        chk("drain_ready", {31'b0, a_ready}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_level", {27'b0, a_level}, 32'd0);
        chk("async_rst_valid", {31'b0, a_valid}, 32'h0);
        chk("async_rst_busy", {31'b0, a_busy}, 32'h0);
        chk("async_rst_data", a_data, 32'h0);
        rst_n = 1'b1;
        follow = 1'b1; src_valid = 1'b1; src_data = 32'hA1;
        do_start(32'd2, 2'd0, 32'h0);
        tick();
        src_data = 32'hA2;
        chk("post_rst_data0", a_data, 32'hA1);
        tick();
        src_valid = 1'b0;
        chk("post_rst_data1", a_data, 32'hA2);
        tick();
        chk("post_rst_done", {31'b0, a_done}, 32'h1);
        chk("post_rst_valid", {31'b0, a_valid}, 32'h0);

        // Error: zero length, then a start that must be ignored
        follow = 1'b0; next_man = 1'b0;
        do_start(32'd0, 2'd0, 32'h0);
        chk("err1_flag", {31'b0, a_error}, 32'h1);
        chk("err1_type", {30'b0, a_etype}, 32'd1);
        do_start(32'd5, 2'd0, 32'h0);
        chk("err1_sticky", {29'b0, a_busy, a_error, a_etype[0]}, 32'b011);
        pulse_reset();

        // Error: illegal format
        do_start(32'd3, 2'd3, 32'h0);
        chk("err2_type", {30'b0, a_etype}, 32'd2);
        do_start(32'd3, 2'd0, 32'h0);
        chk("err2_sticky", {29'b0, a_busy, a_error, a_etype}, 32'b0110);
        pulse_reset();

        // Error: next strobe while the FIFO is empty in RUN
        do_start(32'd3, 2'd0, 32'h0);
        chk("err3_run", {31'b0, a_busy}, 32'h1);
        next_man = 1'b1;
        tick();
        next_man = 1'b0;
        chk("err3_type", {30'b0, a_etype}, 32'd3);
        chk("err3_level", {27'b0, a_level}, 32'd0);
        do_start(32'd3, 2'd0, 32'h0);
        chk("err3_sticky", {29'b0, a_busy, a_error, a_etype}, 32'b0111);
        pulse_reset();
        chk("err_cleared", {30'b0, a_etype}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
